// File: rtl/sum_accum_reg_if.sv
// Stream bundle between the ADD stage, the accumulator and its downstream consumer.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface sum_accum_reg_if #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 10
);
  logic [DATAWIDTH-1:0] d;
  logic                 d_valid;
  logic                 d_ready;
  logic                 clr;
  logic [ACCWIDTH-1:0]  q;
  logic                 q_valid;
  logic                 q_ready;
  logic                 ovf;
  logic [7:0]           beat_cnt;

  modport slave (
    input  d, d_valid, clr, q_ready,
    output d_ready, q, q_valid, ovf, beat_cnt
  );

  modport master (
    output d, d_valid, clr, q_ready,
    input  d_ready, q, q_valid, ovf, beat_cnt
  );
endinterface

// File: rtl/sum_accum_reg.sv
// Frame accumulator: sums LEN accepted beats and holds the result until the consumer takes it.
// Optional macro SUM_ACCUM_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module sum_accum_reg #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 10,
  parameter int LEN       = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  sum_accum_reg_if.slave    bus
);
  typedef enum logic {ST_ACC, ST_OUT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(LEN - 1);

  state_t              state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic [ACCWIDTH-1:0] q_q, q_d;
  logic                ovf_q, ovf_d;
  logic                qv_q, qv_d;

  logic                d_ready;
  logic                xfer;
  logic [ACCWIDTH:0]   sum;
  logic                carry;
  logic [ACCWIDTH-1:0] acc_val;

  assign d_ready = (state_q == ST_ACC) && !bus.clr;
  assign xfer    = bus.d_valid && d_ready;
  assign sum     = {1'b0, acc_q} + {{(ACCWIDTH + 1 - DATAWIDTH){1'b0}}, bus.d};
  assign carry   = sum[ACCWIDTH];

`ifdef SUM_ACCUM_SATURATE_EN
  // Once a frame has overflowed, acc stays pinned at full scale until the frame ends.
  assign acc_val = (carry || sticky_q) ? {ACCWIDTH{1'b1}} : sum[ACCWIDTH-1:0];
`else
  assign acc_val = sum[ACCWIDTH-1:0];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      qv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      qv_q     <= qv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    q_d      = q_q;
    ovf_d    = ovf_q;
    qv_d     = qv_q;
    case (state_q)
      ST_ACC: begin
        if (bus.clr) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else if (xfer) begin
          if (cnt_q == LAST_BEAT) begin
            q_d      = acc_val;
            ovf_d    = sticky_q | carry;
            qv_d     = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            state_d  = ST_OUT;
          end else begin
            acc_d    = acc_val;
            sticky_d = sticky_q | carry;
            cnt_d    = cnt_q + 8'd1;
          end
        end
      end
      ST_OUT: begin
        // clr is deliberately ignored here: a finished frame must always drain.
        if (qv_q && bus.q_ready) begin
          qv_d    = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  assign bus.d_ready  = d_ready;
  assign bus.q        = q_q;
  assign bus.q_valid  = qv_q;
  assign bus.ovf      = ovf_q;
  assign bus.beat_cnt = cnt_q;
endmodule

// File: tb/tb_sum_accum_reg.sv
// Bench for sum_accum_reg: table-driven vectors plus hand sequences, results checked
// against a scoreboard queue filled when each frame's last beat is driven.
module tb_sum_accum_reg;
  logic clk;
  logic rst_n;

  sum_accum_reg_if #(.DATAWIDTH(8), .ACCWIDTH(10)) a ();
  sum_accum_reg_if #(.DATAWIDTH(8), .ACCWIDTH(9))  b ();

  sum_accum_reg #(.DATAWIDTH(8), .ACCWIDTH(10), .LEN(4)) u_dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (a)
  );

  sum_accum_reg #(.DATAWIDTH(8), .ACCWIDTH(9), .LEN(4)) u_dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b)
  );

  typedef struct {
    int q;
    bit ovf;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         dv;
    bit         clr;
    bit         qr;
    bit         exp_dr;
    int         exp_cnt;
    bit         exp_qv;
    bit         push;
    int         exp_q;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[21];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %0d at %0t", name, act, $time);
    end
  endfunction

  function automatic vec_t mk(int d, bit dv, bit clr, bit qr, bit edr, int ecnt, bit eqv,
                              bit push, int eq);
    vec_t v;
    v.d = 8'(d); v.dv = dv; v.clr = clr; v.qr = qr;
    v.exp_dr = edr; v.exp_cnt = ecnt; v.exp_qv = eqv; v.push = push; v.exp_q = eq;
    return v;
  endfunction

  // Scoreboard: every completed handshake on dut_a must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && a.q_valid && a.q_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got q=%0d, expected no result", a.q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_q", int'(a.q), e.q);
        chk("sb_ovf", int'(a.ovf), int'(e.ovf));
      end
    end
  end

  task automatic apply(input vec_t v);
    a.d = v.d; a.d_valid = v.dv; a.clr = v.clr; a.q_ready = v.qr;
    if (v.push) sb.push_back('{q: v.exp_q, ovf: 1'b0});
    @(negedge clk);
    chk("vec_d_ready", int'(a.d_ready), int'(v.exp_dr));
    @(posedge clk); #1;
    chk("vec_beat_cnt", int'(a.beat_cnt), v.exp_cnt);
    chk("vec_q_valid", int'(a.q_valid), int'(v.exp_qv));
  endtask

  task automatic beat_a(input int d, input bit dv, input bit clr, input bit qr);
    a.d = 8'(d); a.d_valid = dv; a.clr = clr; a.q_ready = qr;
    @(posedge clk); #1;
  endtask

  task automatic beat_b(input int d, input bit dv, input bit qr);
    b.d = 8'(d); b.d_valid = dv; b.q_ready = qr;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_sat_q;
`ifdef SUM_ACCUM_SATURATE_EN
    exp_sat_q = 511;
`else
    exp_sat_q = 508;
`endif
    // back-to-back frame, clr abort, gappy d_valid
    tbl[0]  = mk(10, 1, 0, 1, 1, 1, 0, 0, 0);
    tbl[1]  = mk(5,  1, 0, 1, 1, 2, 0, 0, 0);
    tbl[2]  = mk(15, 1, 0, 1, 1, 3, 0, 0, 0);
    tbl[3]  = mk(20, 1, 0, 1, 1, 0, 1, 1, 50);
    tbl[4]  = mk(0,  0, 0, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0,  0, 0, 1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(10, 1, 0, 1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(5,  1, 0, 1, 1, 2, 0, 0, 0);
    tbl[8]  = mk(99, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1,  1, 0, 1, 1, 1, 0, 0, 0);
    tbl[10] = mk(2,  1, 0, 1, 1, 2, 0, 0, 0);
    tbl[11] = mk(3,  1, 0, 1, 1, 3, 0, 0, 0);
    tbl[12] = mk(4,  1, 0, 1, 1, 0, 1, 1, 10);
    tbl[13] = mk(0,  0, 0, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(3,  1, 0, 1, 1, 1, 0, 0, 0);
    tbl[15] = mk(3,  0, 0, 1, 1, 1, 0, 0, 0);
    tbl[16] = mk(3,  1, 0, 1, 1, 2, 0, 0, 0);
    tbl[17] = mk(3,  1, 0, 1, 1, 3, 0, 0, 0);
    tbl[18] = mk(3,  0, 0, 1, 1, 3, 0, 0, 0);
    tbl[19] = mk(3,  1, 0, 1, 1, 0, 1, 1, 12);
    tbl[20] = mk(0,  0, 0, 1, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    a.d = '0; a.d_valid = 1'b0; a.clr = 1'b0; a.q_ready = 1'b0;
    b.d = '0; b.d_valid = 1'b0; b.clr = 1'b0; b.q_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_q_valid", int'(a.q_valid), 0);
    chk("rst_q", int'(a.q), 0);
    chk("rst_ovf", int'(a.ovf), 0);
    chk("rst_beat_cnt", int'(a.beat_cnt), 0);
    chk("rst_d_ready", int'(a.d_ready), 1);
    chk("rst_b_q_valid", int'(b.q_valid), 0);

    for (int i = 0; i < 21; i++) apply(tbl[i]);

    // Result held under back-pressure; clr and d_valid in OUT must be ignored
    beat_a(10, 1, 0, 0);
    beat_a(5,  1, 0, 0);
    beat_a(15, 1, 0, 0);
    sb.push_back('{q: 50, ovf: 1'b0});
    beat_a(20, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      a.d = 8'd77; a.d_valid = 1'b1; a.clr = (i == 2); a.q_ready = 1'b0;
      #1;
      chk("hold_d_ready", int'(a.d_ready), 0);
      chk("hold_q_valid", int'(a.q_valid), 1);
      chk("hold_q", int'(a.q), 50);
      @(posedge clk); #1;
    end
    beat_a(0, 0, 0, 1);
    chk("drain_q_valid", int'(a.q_valid), 0);
    chk("drain_d_ready", int'(a.d_ready), 1);
    chk("drain_q_kept", int'(a.q), 50);
    chk("drain_beat_cnt", int'(a.beat_cnt), 0);

    // Asynchronous reset mid-frame
    beat_a(7, 1, 0, 1);
    beat_a(7, 1, 0, 1);
    beat_a(7, 1, 0, 1);
    a.d_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", int'(a.q), 0);
    chk("arst_q_valid", int'(a.q_valid), 0);
    chk("arst_beat_cnt", int'(a.beat_cnt), 0);
    chk("arst_ovf", int'(a.ovf), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    beat_a(1, 1, 0, 1);
    beat_a(1, 1, 0, 1);
    beat_a(1, 1, 0, 1);
    sb.push_back('{q: 4, ovf: 1'b0});
    beat_a(1, 1, 0, 1);
    chk("arst_frame_q_valid", int'(a.q_valid), 1);
    beat_a(0, 0, 0, 1);
    chk("arst_frame_done", int'(a.q_valid), 0);

    // Overflow on the 9-bit accumulator, then a clean frame to confirm sticky cleared
    for (int i = 0; i < 4; i++) beat_b(255, 1, 0);
    b.d_valid = 1'b0;
    chk("ovf_b_q_valid", int'(b.q_valid), 1);
    chk("ovf_b_q", int'(b.q), exp_sat_q);
    chk("ovf_b_ovf", int'(b.ovf), 1);
    beat_b(0, 0, 1);
    chk("ovf_b_drained", int'(b.q_valid), 0);
    for (int i = 0; i < 4; i++) beat_b(1, 1, 1);
    chk("clean_b_q", int'(b.q), 4);
    chk("clean_b_ovf", int'(b.ovf), 0);
    beat_b(0, 0, 1);
    chk("clean_b_drained", int'(b.q_valid), 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
